multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the program counter's advance strobe and source select, the instruction-register load, the memory request handshake and register-file write enable.
- Sits between the instruction register/ALU flags and the PC, memory port and register file.

---
 rtl/multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM for the multi-cycle RV32I core. It moves each instruction
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). It also drives the PC
// advance strobe, the instruction-register load, the memory handshake and the
// register-file write enable.
//
// Parameters
//   MEM_TIMEOUT  cycles a memory request may wait for mem_ready (1..255)
//   AUTO_RUN     1 = leave IDLE right after reset, 0 = wait for run
//
// Ports
//   sys_clk       in   system clock, rising edge
//   sys_rst       in   synchronous active-high reset
//   run           in   start request, sampled only in IDLE
//   opcode[6:0]   in   instruction bits [6:0] from the instruction register
//   branch_cond   in   ALU branch comparison, 1 = taken
//   mem_ready     in   memory completion for the current request
//   pc_op         out  PC advance strobe, one pulse per retired instruction
//   pc_src        out  PC source, 0 = sequential, 1 = ALU result
//   ir_load       out  instruction-register load
//   mem_req       out  memory request
//   mem_we        out  memory write
//   mem_addr_sel  out  memory address source, 0 = PC, 1 = ALU result
//   reg_we        out  register-file write enable
//   wb_sel[1:0]   out  writeback source, 0 = ALU, 1 = memory, 2 = PC+4
//   state[2:0]    out  current FSM state
//   retired       out  retire pulse, coincident with pc_op
//   illegal       out  sticky illegal-opcode trap flag
//   timeout       out  sticky memory-timeout trap flag
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter bit AUTO_RUN    = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       branch_cond,
    input  logic       mem_ready,
    output logic       pc_op,
    output logic       pc_src,
    output logic       ir_load,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic [2:0] state,
    output logic       retired,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_LUI    = 4'd0,
        C_AUIPC  = 4'd1,
        C_JAL    = 4'd2,
        C_JALR   = 4'd3,
        C_BRANCH = 4'd4,
        C_LOAD   = 4'd5,
        C_STORE  = 4'd6,
        C_OPIMM  = 4'd7,
        C_OP     = 4'd8
    } iclass_t;

    // The last count that is still allowed to wait. If mem_ready is still low
    // at this count, the core traps.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     st;
    iclass_t    cls;
    logic [7:0] wait_cnt;

    iclass_t    dec_class;
    logic       dec_legal;
    logic       wait_expired;

    assign state        = st;
    assign wait_expired = (wait_cnt == WAIT_LAST);

    // Opcode classification. It is only consumed in DECODE.
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        dec_class = C_LUI;
        dec_legal = 1'b1;
        case (opcode)
            7'b0110111: dec_class = C_LUI;
            7'b0010111: dec_class = C_AUIPC;
            7'b1101111: dec_class = C_JAL;
            7'b1100111: dec_class = C_JALR;
            7'b1100011: dec_class = C_BRANCH;
            7'b0000011: dec_class = C_LOAD;
            7'b0100011: dec_class = C_STORE;
            7'b0010011: dec_class = C_OPIMM;
            7'b0110011: dec_class = C_OP;
            default:    dec_legal = 1'b0;
        endcase
    end

    // State, class, wait counter and sticky trap flags. The wait counter is
    // only non-zero while a FETCH or MEM cycle is waiting. Every exit from
    // those states clears it, so it reads zero on entry to any state.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            st       <= S_IDLE;
            cls      <= C_LUI;
            wait_cnt <= 8'd0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (AUTO_RUN || run) st <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        wait_cnt <= 8'd0;
                        st       <= S_DECODE;
                    end else if (wait_expired) begin
                        wait_cnt <= 8'd0;
                        timeout  <= 1'b1;
                        st       <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    cls <= dec_class;
                    if (dec_legal) begin
                        st <= S_EXEC;
                    end else begin
                        illegal <= 1'b1;
                        st      <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_BRANCH:        st <= S_FETCH;
                        C_LOAD, C_STORE: st <= S_MEM;
                        default:         st <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= 8'd0;
                        st       <= (cls == C_STORE) ? S_FETCH : S_WB;
                    end else if (wait_expired) begin
                        wait_cnt <= 8'd0;
                        timeout  <= 1'b1;
                        st       <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB:    st <= S_FETCH;
                S_TRAP:  st <= S_TRAP;
                default: st <= S_TRAP;   // encoding 7 is never entered legally
            endcase
        end
    end

    // Control outputs are decoded from the registered state and class plus
    // the live mem_ready and branch_cond inputs. IDLE and TRAP fall through
    // with all defaults at zero.
    always_comb begin
        pc_op        = 1'b0;
        pc_src       = 1'b0;
        ir_load      = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        retired      = 1'b0;
        case (st)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
            end
            S_EXEC: begin
                if (cls == C_BRANCH) begin
                    pc_op   = 1'b1;
                    pc_src  = branch_cond;
                    retired = 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == C_STORE);
                if (mem_ready && cls == C_STORE) begin
                    pc_op   = 1'b1;
                    retired = 1'b1;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_op   = 1'b1;
                retired = 1'b1;
                if (cls == C_LOAD) begin
                    wb_sel = 2'd1;
                end else if (cls == C_JAL || cls == C_JALR) begin
                    wb_sel = 2'd2;
                    pc_src = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. It uses two queues:
//   exp_q  per-cycle expected state and control vector, plus the mem_ready
//          value to drive in that cycle; drained by trace().
//   sb_q   expected retirement record {state, pc_src, reg_we, wb_sel},
//          pushed before each instruction. An independent monitor pops one
//          entry whenever pc_op is seen high.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5,
                           S_TRAP = 3'd6;

    // Expected {ir_load, mem_req, mem_we, mem_addr_sel, reg_we, pc_op}
    localparam logic [5:0] K_NONE = 6'b000000;
    localparam logic [5:0] K_FR   = 6'b110000;  // FETCH, memory ready
    localparam logic [5:0] K_FW   = 6'b010000;  // FETCH, waiting
    localparam logic [5:0] K_ML   = 6'b010100;  // MEM load
    localparam logic [5:0] K_MS   = 6'b011100;  // MEM store waiting
    localparam logic [5:0] K_MSD  = 6'b011101;  // MEM store completing
    localparam logic [5:0] K_BR   = 6'b000001;  // EXEC branch
    localparam logic [5:0] K_WB   = 6'b000011;  // WB

    localparam logic [6:0] OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_JAL   = 7'b1101111, OP_JALR  = 7'b1100111,
                           OP_BR    = 7'b1100011, OP_LOAD  = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM   = 7'b0010011,
                           OP_OP    = 7'b0110011, OP_BAD   = 7'b0000000;

    logic       sys_clk;
    logic       sys_rst;
    logic       run;
    logic [6:0] opcode;
    logic       branch_cond;
    logic       mem_ready;
    logic       pc_op, pc_src, ir_load, mem_req, mem_we, mem_addr_sel, reg_we;
    logic [1:0] wb_sel;
    logic [2:0] state;
    logic       retired, illegal, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] exp_q [$];   // {mem_ready drive, state, ctl[5:0], illegal, timeout}
    logic [6:0]  sb_q  [$];   // {state, pc_src, reg_we, wb_sel}

    multicycle_ctrl #(.MEM_TIMEOUT(15), .AUTO_RUN(1'b1)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .run          (run),
        .opcode       (opcode),
        .branch_cond  (branch_cond),
        .mem_ready    (mem_ready),
        .pc_op        (pc_op),
        .pc_src       (pc_src),
        .ir_load      (ir_load),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .state        (state),
        .retired      (retired),
        .illegal      (illegal),
        .timeout      (timeout)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic add(input logic mr, input logic [2:0] st, input logic [5:0] ctl,
                       input logic [1:0] fl);
        exp_q.push_back({mr, st, ctl, fl});
    endtask

    task automatic expect_retire(input logic [2:0] st, input logic src, input logic rwe,
                                 input logic [1:0] wb);
        sb_q.push_back({st, src, rwe, wb});
    endtask

    // Plays the queued per-cycle expectations, one clock per entry.
    task automatic trace(input string nm);
        int i = 0;
        while (exp_q.size() > 0) begin
            logic [11:0] e;
            e = exp_q.pop_front();
            mem_ready = e[11];
            @(negedge sys_clk);
            check($sformatf("%s[%0d]", nm, i),
                  {state, ir_load, mem_req, mem_we, mem_addr_sel, reg_we, pc_op,
                   illegal, timeout}, e[10:0]);
            check($sformatf("%s[%0d].retired", nm, i), retired, e[2]);
            if (e[10:8] == S_IDLE || e[10:8] == S_TRAP)
                check($sformatf("%s[%0d].src_wb", nm, i), {pc_src, wb_sel}, 3'b000);
            tick();
            i++;
        end
    endtask

    task automatic do_reset(input string nm);
        sys_rst   = 1'b1;
        mem_ready = 1'b0;
        tick();
        @(negedge sys_clk);
        check({nm, ".state"}, state, S_IDLE);
        check({nm, ".outs"}, {pc_op, pc_src, ir_load, mem_req, mem_we, mem_addr_sel,
                              reg_we, wb_sel, retired, illegal, timeout}, 12'h000);
        tick();
        sys_rst = 1'b0;
    endtask

    // F, D, E, WB with zero-wait fetch.
    task automatic seq_wb(input logic [6:0] op, input logic src, input logic [1:0] wb);
        opcode = op;
        add(1'b1, S_FETCH,  K_FR,   2'b00);
        add(1'b1, S_DECODE, K_NONE, 2'b00);
        add(1'b1, S_EXEC,   K_NONE, 2'b00);
        add(1'b1, S_WB,     K_WB,   2'b00);
        expect_retire(S_WB, src, 1'b1, wb);
    endtask

    task automatic seq_branch(input logic taken);
        opcode      = OP_BR;
        branch_cond = taken;
        add(1'b1, S_FETCH,  K_FR,   2'b00);
        add(1'b1, S_DECODE, K_NONE, 2'b00);
        add(1'b1, S_EXEC,   K_BR,   2'b00);
        expect_retire(S_EXEC, taken, 1'b0, 2'd0);
    endtask

    // Scoreboard monitor: one expected record per pc_op pulse.
    always @(negedge sys_clk) begin : monitor
        logic [6:0] e;
        if (pc_op === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL retire_unexpected: got pc_op=1 in state %0d, expected no retirement",
                         state);
            end else begin
                e = sb_q.pop_front();
                check("retire", {state, pc_src, reg_we, wb_sel}, e);
            end
        end
    end

    initial begin
        sys_rst     = 1'b1;
        run         = 1'b0;
        opcode      = OP_BAD;
        branch_cond = 1'b0;
        mem_ready   = 1'b0;

        do_reset("reset0");

        // ADDI from IDLE: states 0,1,2,3,5 and then back to FETCH.
        opcode = OP_IMM;
        add(1'b1, S_IDLE, K_NONE, 2'b00);
        seq_wb(OP_IMM, 1'b0, 2'd0);
        trace("addi");

        // Branch taken, then not taken: 3 cycles each.
        seq_branch(1'b1);
        trace("br_taken");
        seq_branch(1'b0);
        trace("br_not");

        // LOAD with three MEM wait cycles.
        opcode = OP_LOAD;
        add(1'b1, S_FETCH,  K_FR,   2'b00);
        add(1'b1, S_DECODE, K_NONE, 2'b00);
        add(1'b1, S_EXEC,   K_NONE, 2'b00);
        add(1'b0, S_MEM,    K_ML,   2'b00);
        add(1'b0, S_MEM,    K_ML,   2'b00);
        add(1'b0, S_MEM,    K_ML,   2'b00);
        add(1'b1, S_MEM,    K_ML,   2'b00);
        add(1'b1, S_WB,     K_WB,   2'b00);
        expect_retire(S_WB, 1'b0, 1'b1, 2'd1);
        trace("load");

        // STORE with one MEM wait cycle, retiring from MEM.
        opcode = OP_STORE;
        add(1'b1, S_FETCH,  K_FR,   2'b00);
        add(1'b1, S_DECODE, K_NONE, 2'b00);
        add(1'b1, S_EXEC,   K_NONE, 2'b00);
        add(1'b0, S_MEM,    K_MS,   2'b00);
        add(1'b1, S_MEM,    K_MSD,  2'b00);
        expect_retire(S_MEM, 1'b0, 1'b0, 2'd0);
        trace("store");

        seq_wb(OP_JAL,   1'b1, 2'd2); trace("jal");
        seq_wb(OP_JALR,  1'b1, 2'd2); trace("jalr");
        seq_wb(OP_LUI,   1'b0, 2'd0); trace("lui");
        seq_wb(OP_AUIPC, 1'b0, 2'd0); trace("auipc");

        // OP with mem_ready low outside FETCH: no stall expected.
        opcode = OP_OP;
        add(1'b1, S_FETCH,  K_FR,   2'b00);
        add(1'b0, S_DECODE, K_NONE, 2'b00);
        add(1'b0, S_EXEC,   K_NONE, 2'b00);
        add(1'b0, S_WB,     K_WB,   2'b00);
        expect_retire(S_WB, 1'b0, 1'b1, 2'd0);
        trace("op_mr_low");

        // Illegal opcode traps after DECODE and holds for 20 cycles.
        opcode = OP_BAD;
        add(1'b1, S_FETCH,  K_FR,   2'b00);
        add(1'b1, S_DECODE, K_NONE, 2'b00);
        repeat (20) add(1'b1, S_TRAP, K_NONE, 2'b10);
        trace("illegal");
        do_reset("reset_illegal");

        // FETCH timeout: 15 waiting cycles, then TRAP with timeout set.
        opcode = OP_IMM;
        add(1'b0, S_IDLE, K_NONE, 2'b00);
        repeat (15) add(1'b0, S_FETCH, K_FW, 2'b00);
        repeat (3)  add(1'b1, S_TRAP,  K_NONE, 2'b01);
        trace("fetch_timeout");
        do_reset("reset_timeout");

        // Reset mid-MEM overrides a coincident mem_ready.
        opcode = OP_LOAD;
        add(1'b1, S_IDLE,   K_NONE, 2'b00);
        add(1'b1, S_FETCH,  K_FR,   2'b00);
        add(1'b1, S_DECODE, K_NONE, 2'b00);
        add(1'b1, S_EXEC,   K_NONE, 2'b00);
        add(1'b0, S_MEM,    K_ML,   2'b00);
        trace("midmem");
        sys_rst   = 1'b1;
        mem_ready = 1'b1;
        @(negedge sys_clk);
        check("midmem_pre.state", state, S_MEM);
        check("midmem_pre.mem_req", mem_req, 1'b1);
        tick();
        @(negedge sys_clk);
        check("midmem_post.state", state, S_IDLE);
        check("midmem_post.mem_req", mem_req, 1'b0);
        check("midmem_post.outs", {pc_op, ir_load, mem_addr_sel, reg_we, retired}, 5'b00000);
        tick();
        sys_rst   = 1'b0;
        mem_ready = 1'b0;

        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
